// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/dmem_arbiter_arb_rr2.sv
// Two-way combinational arbiter: masked requests, round-robin or fixed-priority tie break.
module arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    input  logic       fixed_prio,
    output logic       valid,
    output logic       winner
);

    logic [1:0] elig;

    assign elig  = req & ~mask;
    assign valid = |elig;

    always_comb begin
        winner = M_CPU;
        if (elig == 2'b11) begin
            winner = fixed_prio ? M_CPU : ~last;
        end else if (elig[1]) begin
            winner = M_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU (master 0) and the loader/debug port
// (master 1); one registered command per cycle, read data returned one edge after issue.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state_reg;
    logic              last_gnt_reg;
    logic              rd_pend_reg;
    logic              rd_master_reg;
    logic [1:0]        gnt_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic              arb_valid;
    logic              arb_winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // The master granted in the cycle just ending is masked so a requester that is
    // still dropping req after seeing gnt cannot be issued twice.
    arb_rr2 u_arb (
        .req        ({m1_req, m0_req}),
        .mask       (gnt_reg),
        .last       (last_gnt_reg),
        .fixed_prio (FIXED_PRIO != 0),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign sel_we    = (arb_winner == M_DBG) ? m1_we    : m0_we;
    assign sel_addr  = (arb_winner == M_DBG) ? m1_addr  : m0_addr;
    assign sel_wdata = (arb_winner == M_DBG) ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            last_gnt_reg  <= M_DBG;
            rd_pend_reg   <= 1'b0;
            rd_master_reg <= M_CPU;
            gnt_reg       <= 2'b00;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else if (arb_valid) begin
            state_reg     <= ST_ISSUE;
            last_gnt_reg  <= arb_winner;
            rd_pend_reg   <= ~sel_we;
            rd_master_reg <= arb_winner;
            gnt_reg       <= (arb_winner == M_DBG) ? 2'b10 : 2'b01;
            mem_read_reg  <= ~sel_we;
            mem_write_reg <= sel_we;
            mem_addr_reg  <= sel_addr;
            mem_wdata_reg <= sel_wdata;
        end else begin
            state_reg     <= ST_IDLE;
            rd_pend_reg   <= 1'b0;
            gnt_reg       <= 2'b00;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
        end
    end

    // Per-master read return: capture memory data at the edge that ends a read issue.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        localparam logic ID = 1'(gi);
        logic              rvalid_reg;
        logic [DATA_W-1:0] rdata_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rvalid_reg <= 1'b0;
                rdata_reg  <= '0;
            end else begin
                rvalid_reg <= rd_pend_reg && (rd_master_reg == ID);
                if (rd_pend_reg && (rd_master_reg == ID)) begin
                    rdata_reg <= mem_rdata;
                end
            end
        end
    end

    assign m0_gnt    = gnt_reg[0];
    assign m1_gnt    = gnt_reg[1];
    assign m0_rvalid = g_ret[0].rvalid_reg;
    assign m0_rdata  = g_ret[0].rdata_reg;
    assign m1_rvalid = g_ret[1].rvalid_reg;
    assign m1_rdata  = g_ret[1].rdata_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = (state_reg == ST_ISSUE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin instance with a small memory model, plus a fixed-priority instance.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // round-robin DUT signals
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [15:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic        mem_read, mem_write, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    // fixed-priority DUT signals
    logic        fp_m0_req = 0, fp_m1_req = 0;
    logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
    logic [15:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_mem_read, fp_mem_write, fp_busy;
    logic [15:0] fp_mem_addr, fp_mem_wdata, fp_mem_rdata;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset),
        .m0_req(fp_m0_req), .m0_we(1'b0), .m0_addr(16'h0030), .m0_wdata(16'h0000),
        .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
        .m1_req(fp_m1_req), .m1_we(1'b0), .m1_addr(16'h0031), .m1_wdata(16'h0000),
        .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
        .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata), .busy(fp_busy)
    );

    // Memory model: combinational read, posedge write; unwritten words read as {a, ~a}.
    logic [15:0]  mem_arr [0:255];
    logic [255:0] written = '0;
    always @(posedge clk) begin
        if (mem_write) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
            written[mem_addr[7:0]] <= 1'b1;
        end
    end
    assign mem_rdata    = written[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]]
                                                 : {mem_addr[7:0], ~mem_addr[7:0]};
    assign fp_mem_rdata = fp_mem_addr ^ 16'hA5A5;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r0, w0; logic [15:0] a0, d0;
        logic        r1, w1; logic [15:0] a1, d1;
        logic        g0, g1, mr, mw; logic [15:0] ma, md;
        logic        v0, v1; logic [15:0] rd0, rd1; logic bsy;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    typedef struct { logic r0, r1, g0, g1; } fpv_t;
    localparam int NF = 10;
    fpv_t fpv [NF];

    initial begin
        //           r0 w0 a0       d0       r1 w1 a1       d1        g0 g1 mr mw ma       md       v0 v1 rd0      rd1      busy
        vecs[0]  = '{1, 0, 16'h0001, 16'h0000, 1, 0, 16'h0002, 16'h0000, 1, 0, 1, 0, 16'h0001, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1};
        vecs[1]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0002, 16'h0000, 0, 1, 1, 0, 16'h0002, 16'h0000, 1, 0, 16'h01FE, 16'h0000, 1};
        vecs[2]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h01FE, 16'h02FD, 0};
        vecs[3]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h01FE, 16'h02FD, 0};
        vecs[4]  = '{1, 1, 16'h0005, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0005, 16'hBEEF, 0, 0, 16'h01FE, 16'h02FD, 1};
        vecs[5]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h01FE, 16'h02FD, 0};
        vecs[6]  = '{1, 0, 16'h0005, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0005, 16'h0000, 0, 0, 16'h01FE, 16'h02FD, 1};
        vecs[7]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hBEEF, 16'h02FD, 0};
        vecs[8]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hBEEF, 16'h02FD, 0};
        vecs[9]  = '{1, 0, 16'h0005, 16'h0000, 1, 1, 16'h0007, 16'h1357, 0, 1, 0, 1, 16'h0007, 16'h1357, 0, 0, 16'hBEEF, 16'h02FD, 1};
        vecs[10] = '{1, 0, 16'h0005, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0005, 16'h0000, 0, 0, 16'hBEEF, 16'h02FD, 1};
        vecs[11] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hBEEF, 16'h02FD, 0};
        vecs[12] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0007, 16'h0000, 0, 1, 1, 0, 16'h0007, 16'h0000, 0, 0, 16'hBEEF, 16'h02FD, 1};
        vecs[13] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 16'h1357, 0};
        vecs[14] = '{1, 1, 16'h0009, 16'h0042, 1, 1, 16'h0009, 16'h0099, 1, 0, 0, 1, 16'h0009, 16'h0042, 0, 0, 16'hBEEF, 16'h1357, 1};
        vecs[15] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0009, 16'h0099, 0, 1, 0, 1, 16'h0009, 16'h0099, 0, 0, 16'hBEEF, 16'h1357, 1};
        vecs[16] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0009, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hBEEF, 16'h1357, 0};
        vecs[17] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0009, 16'h0000, 0, 1, 1, 0, 16'h0009, 16'h0000, 0, 0, 16'hBEEF, 16'h1357, 1};
        vecs[18] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 16'h0099, 0};
        vecs[19] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hBEEF, 16'h0099, 0};

        // fixed priority: {r0, r1, expected g0, expected g1}
        fpv[0] = '{1, 0, 1, 0};
        fpv[1] = '{0, 0, 0, 0};
        fpv[2] = '{1, 1, 1, 0};
        fpv[3] = '{0, 1, 0, 1};
        fpv[4] = '{1, 1, 1, 0};
        fpv[5] = '{1, 1, 0, 1};
        fpv[6] = '{1, 1, 1, 0};
        fpv[7] = '{0, 1, 0, 1};
        fpv[8] = '{0, 1, 0, 0};
        fpv[9] = '{0, 1, 0, 1};

        // reset state
        #1;
        chk("rst.gnt",    {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("rst.rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("rst.rdata",  {m1_rdata, m0_rdata}, 32'd0);
        chk("rst.memcmd", {30'd0, mem_write, mem_read}, 32'd0);
        chk("rst.memad",  {mem_addr, mem_wdata}, 32'd0);
        chk("rst.busy",   {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // table-driven cycle vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            m0_req = vecs[i].r0; m0_we = vecs[i].w0; m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
            m1_req = vecs[i].r1; m1_we = vecs[i].w1; m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1;
            @(posedge clk); #1;
            chk($sformatf("v%0d.g0", i),   {31'd0, m0_gnt},    {31'd0, vecs[i].g0});
            chk($sformatf("v%0d.g1", i),   {31'd0, m1_gnt},    {31'd0, vecs[i].g1});
            chk($sformatf("v%0d.mr", i),   {31'd0, mem_read},  {31'd0, vecs[i].mr});
            chk($sformatf("v%0d.mw", i),   {31'd0, mem_write}, {31'd0, vecs[i].mw});
            chk($sformatf("v%0d.busy", i), {31'd0, busy},      {31'd0, vecs[i].bsy});
            chk($sformatf("v%0d.v0", i),   {31'd0, m0_rvalid}, {31'd0, vecs[i].v0});
            chk($sformatf("v%0d.v1", i),   {31'd0, m1_rvalid}, {31'd0, vecs[i].v1});
            chk($sformatf("v%0d.rd0", i),  {16'd0, m0_rdata},  {16'd0, vecs[i].rd0});
            chk($sformatf("v%0d.rd1", i),  {16'd0, m1_rdata},  {16'd0, vecs[i].rd1});
            if (vecs[i].mr || vecs[i].mw)
                chk($sformatf("v%0d.addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].ma});
            if (vecs[i].mw)
                chk($sformatf("v%0d.wdata", i), {16'd0, mem_wdata}, {16'd0, vecs[i].md});
            $display("vec %0d: gnt=%b%b rd=%b wr=%b addr=%h rvalid=%b%b busy=%b",
                     i, m1_gnt, m0_gnt, mem_read, mem_write, mem_addr, m1_rvalid, m0_rvalid, busy);
        end

        // cancel before grant: m1 pulses req entirely inside m0's issue cycle
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 16'h0003;
        @(posedge clk); #1;
        chk("cancel.g0", {31'd0, m0_gnt}, 32'd1);
        @(negedge clk);
        m0_req = 0;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0004;
        #2 m1_req = 0;
        @(posedge clk); #1;
        chk("cancel.g1",   {31'd0, m1_gnt}, 32'd0);
        chk("cancel.cmd",  {30'd0, mem_write, mem_read}, 32'd0);
        chk("cancel.busy", {31'd0, busy}, 32'd0);
        chk("cancel.rd0",  {16'd0, m0_rdata}, 32'h0000_03FC);
        $display("cancel: gnt=%b%b busy=%b m0_rdata=%h", m1_gnt, m0_gnt, busy, m0_rdata);

        // sustained round-robin contention; m0 was granted last, so m1 leads
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0020;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rr%0d.g0", k), {31'd0, m0_gnt}, {31'd0, (k % 2) == 1});
            chk($sformatf("rr%0d.g1", k), {31'd0, m1_gnt}, {31'd0, (k % 2) == 0});
            $display("rr %0d: gnt=%b%b", k, m1_gnt, m0_gnt);
        end
        @(negedge clk);
        m0_req = 0; m1_req = 0;
        @(posedge clk); #1;
        chk("rr.last_v0", {31'd0, m0_rvalid}, 32'd1);
        chk("rr.rd0", {16'd0, m0_rdata}, 32'h0000_10EF);
        @(negedge clk);

        // reset mid-read
        m0_req = 1; m0_we = 0; m0_addr = 16'h0005;
        @(posedge clk); #1;
        chk("rstmid.g0", {31'd0, m0_gnt}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid.gnt",   {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("rstmid.cmd",   {30'd0, mem_write, mem_read}, 32'd0);
        chk("rstmid.addr",  {16'd0, mem_addr}, 32'd0);
        chk("rstmid.rdata", {m1_rdata, m0_rdata}, 32'd0);
        chk("rstmid.busy",  {31'd0, busy}, 32'd0);
        @(negedge clk);
        m0_req = 0;
        @(posedge clk); #1;
        chk("rstmid.v0a", {31'd0, m0_rvalid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstmid.v0b", {31'd0, m0_rvalid}, 32'd0);
        @(negedge clk);
        m0_req = 1; m0_addr = 16'h0001;
        m1_req = 1; m1_addr = 16'h0002;
        @(posedge clk); #1;
        chk("rstmid.first_g0", {31'd0, m0_gnt}, 32'd1);
        chk("rstmid.first_g1", {31'd0, m1_gnt}, 32'd0);
        @(negedge clk);
        m0_req = 0;
        @(posedge clk); #1;
        chk("rstmid.second_g1", {31'd0, m1_gnt}, 32'd1);
        @(negedge clk);
        m1_req = 0;
        $display("reset-mid-read: sequence done");

        // fixed priority instance
        for (int i = 0; i < NF; i++) begin
            @(negedge clk);
            fp_m0_req = fpv[i].r0; fp_m1_req = fpv[i].r1;
            @(posedge clk); #1;
            chk($sformatf("fp%0d.g0", i), {31'd0, fp_m0_gnt}, {31'd0, fpv[i].g0});
            chk($sformatf("fp%0d.g1", i), {31'd0, fp_m1_gnt}, {31'd0, fpv[i].g1});
            chk($sformatf("fp%0d.mr", i), {31'd0, fp_mem_read}, {31'd0, fpv[i].g0 | fpv[i].g1});
            $display("fp %0d: req=%b%b gnt=%b%b", i, fp_m1_req, fp_m0_req, fp_m1_gnt, fp_m0_gnt);
        end
        @(negedge clk);
        fp_m0_req = 0; fp_m1_req = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters: master 0 (CPU load/store path) and master 1 (program loader / debug port).
- Arbitrates per transaction (round-robin or fixed priority) and drives the memory's read/write/address/write-data inputs from registers.
- Returns read data to the winning master with a one-cycle valid pulse.
- Sits between the CPU top and the data memory; the memory itself is unchanged (combinational read, posedge write).

Parameters:
- ADDR_W, 16, address width passed to the memory.
- DATA_W, 16, data width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins ties.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- m0_req  in  1  master 0 transaction request; level, held until m0_gnt.
- m0_we  in  1  master 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 command issued this cycle.
- m0_rvalid  out  1  master 0 read data valid (1-cycle pulse).
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as master 0, for master 1.
- mem_read  out  1  to data memory read enable.
- mem_write  out  1  to data memory write enable.
- mem_addr  out  ADDR_W  to data memory address.
- mem_wdata  out  DATA_W  to data memory write data.
- mem_rdata  in  DATA_W  from data memory read data.
- busy  out  1  high while in ISSUE.

Behaviour:
- Reset values:
  - All outputs are 0: gnt, rvalid, rdata, mem_*, busy.
  - State is IDLE, last_gnt = 1 (master 0 wins the first tie), rd_pend = 0.
- FSM has two states:
  - IDLE: no command on the memory.
  - ISSUE: exactly one command on the memory for one cycle.
- Arbitration at each posedge. Eligible masters are those with reqN = 1, excluding the master granted in the cycle just ending. This masking prevents double-issue while the requester drops req after seeing gnt.
  - No eligible master -> IDLE, and mem_read/mem_write/gnt return to 0.
  - One eligible master -> ISSUE for it.
  - Both eligible with FIXED_PRIO = 0 -> grant the master != last_gnt.
  - Both eligible with FIXED_PRIO = 1 -> master 0.
- On entering ISSUE for master N, the following are registered:
  - mem_addr = mN_addr, mem_wdata = mN_wdata.
  - mem_write = mN_we, mem_read = !mN_we.
  - mN_gnt = 1, last_gnt = N.
- ISSUE lasts one cycle. The next edge re-arbitrates, so back-to-back alternating grants between masters are allowed (throughput 1 transaction/cycle).
- The same master is served at most every other cycle.
- The write commits at the posedge ending the ISSUE cycle.
- Read path:
  - At the posedge ending a read ISSUE, mem_rdata is captured into mN_rdata and mN_rvalid = 1 for one cycle.
  - Read latency is 2 edges from the req-sampling edge (req sampled at edge k, gnt during k..k+1, rvalid during k+1..k+2).
- rdata holds its last value when rvalid = 0. The other master's rdata is unaffected.
- rvalid of one master may coincide with gnt of the other.
- Requester contract:
  - mN_we/addr/wdata are stable while req = 1.
  - Deasserting req before gnt is a legal cancel: that master is not issued if req is low at the sampling edge.
- Reset asserted mid-transaction clears everything asynchronously:
  - A pending read produces no rvalid.
  - A write in ISSUE at the reset edge is not guaranteed to commit.
  - After reset deassert, the first arbitration happens at the next posedge.
- Width rules: addresses and data pass through unmodified; no truncation inside the block.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum (ST_IDLE = 0, ST_ISSUE = 1);
  - master IDs (M_CPU = 0, M_DBG = 1);
  - default widths.
- One combinational sub-module, arb_rr2, is natural. Inputs: req[1:0], mask[1:0], last, fixed_prio. Outputs: valid, winner.
- The FSM, command registers and read-return registers stay in dmem_arbiter.

Test Plan:
- Single write then read, master 0:
  - Stimulus: m0 write addr 0x0005 data 0xBEEF, then m0 read addr 0x0005.
  - Response: m0_gnt high one cycle each; mem_write = 1 with addr 5 / data 0xBEEF; m0_rvalid pulse with m0_rdata = 0xBEEF two edges after the read req is sampled.
- Simultaneous requests from reset:
  - Stimulus: m0 read 0x0001 and m1 read 0x0002 requested together, both holding req until gnt.
  - Response: m0 granted first, m1 next cycle (back-to-back); rvalids arrive in the same order with the correct data; busy high 2 cycles.
- Sustained contention, round-robin:
  - Stimulus: both masters re-request immediately after each gnt for 10 transactions, FIXED_PRIO = 0.
  - Response: grants strictly alternate 0, 1, 0, 1…; no master gets two consecutive grants.
- Fixed priority:
  - Stimulus: FIXED_PRIO = 1, m0 requesting every other cycle, m1 continuously.
  - Response: m0 wins whenever eligible; m1 is granted only in cycles where m0 is masked or idle.
- Cancel before grant:
  - Stimulus: m1 raises req while m0 is in ISSUE, then drops it before the sampling edge.
  - Response: no m1_gnt, no memory command, FSM returns to IDLE.
- Reset mid-read:
  - Stimulus: assert reset during a m0 read ISSUE cycle, asynchronously between edges.
  - Response: all outputs go to 0 immediately; no m0_rvalid afterwards; the next simultaneous request is granted to m0.
